video_stream_sink: RTL

- Consumes the RGB pixel test-pattern stream (24-bit data, valid/ready, sof, eol) directly downstream of the pattern generator.
- Checks frame and line framing against the configured geometry.
- Buffers accepted pixels in a small show-ahead FIFO.
- Re-emits them as an AXI4-Stream video interface (tuser = start of frame, tlast = end of line) toward the Zynq video DMA/VDMA.

---
 rtl/video_stream_sink_pkg.sv | 18 +
 rtl/video_stream_sink_if.sv | 30 +++
 rtl/video_stream_sink_sync_fifo.sv | 55 +++++
 rtl/video_stream_sink.sv | 116 +++++++++++
 4 files changed

// File: rtl/video_stream_sink_pkg.sv
// Shared defaults, error bit positions and framing state type for the video stream sink.
package video_stream_pkg;

  localparam int unsigned PIXEL_W_DEFAULT     = 24;
  localparam int unsigned LINE_PIXELS_DEFAULT = 1920;
  localparam int unsigned FRAME_LINES_DEFAULT = 1080;

  localparam int unsigned ERR_W           = 3;
  localparam int unsigned ERR_EARLY_EOL   = 0;
  localparam int unsigned ERR_MISSING_EOL = 1;
  localparam int unsigned ERR_UNEXP_SOF   = 2;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

endpackage

// File: rtl/video_stream_sink_if.sv
// Pixel test-pattern stream (valid/ready/sof/eol) and AXI4-Stream video bundles.
interface pixel_stream_if
  import video_stream_pkg::*;
#(
  parameter int unsigned PIXEL_W = PIXEL_W_DEFAULT
) ();
  logic [PIXEL_W-1:0] data;
  logic               data_valid;
  logic               data_ready;
  logic               sof;
  logic               eol;

  modport master (output data, output data_valid, output sof, output eol, input data_ready);
  modport slave  (input data, input data_valid, input sof, input eol, output data_ready);
endinterface

interface axis_video_if
  import video_stream_pkg::*;
#(
  parameter int unsigned PIXEL_W = PIXEL_W_DEFAULT
) ();
  logic [PIXEL_W-1:0] tdata;
  logic               tvalid;
  logic               tready;
  logic               tuser;
  logic               tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_stream_sink_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry always visible on o_rd_data, no write bypass.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             wr;
  logic             rd;

  assign wr        = i_wr_en && !o_full;
  assign rd        = i_rd_en && !o_empty;
  assign o_full    = (count == CW'(DEPTH));
  assign o_empty   = (count == CW'(0));
  assign o_count   = count;
  assign o_rd_data = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= i_wr_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_stream_sink.sv
// Checks pixel-stream framing against the configured geometry, buffers accepted
// pixels and re-emits them as AXI4-Stream video (tuser = sof, tlast = eol).
module video_stream_sink
  import video_stream_pkg::*;
#(
  parameter int unsigned PIXEL_W     = PIXEL_W_DEFAULT,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned LINE_PIXELS = LINE_PIXELS_DEFAULT,
  parameter int unsigned FRAME_LINES = FRAME_LINES_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  pixel_stream_if.slave          s_pix,
  axis_video_if.master           m_axis,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_frame_done,
  output logic [ERR_W-1:0]       o_err,
  input  logic                   i_clear_err
);

  localparam int unsigned ENTRY_W = PIXEL_W + 2;
  localparam int unsigned PX_W    = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int unsigned LN_W    = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(LINE_PIXELS - 1);
  localparam logic [LN_W-1:0] LN_LAST = LN_W'(FRAME_LINES - 1);

  frame_state_t       state;
  logic [PX_W-1:0]    px;
  logic [LN_W-1:0]    ln;
  logic [PX_W-1:0]    cur_px;
  logic [LN_W-1:0]    cur_ln;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               wr_en;
  logic               rd_en;
  logic               eol_fix;
  logic               line_end;
  logic               frame_end;
  logic [ERR_W-1:0]   err_set;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign s_pix.data_ready = !fifo_full;
  assign accept           = s_pix.data_valid && !fifo_full;
  assign rd_en            = m_axis.tvalid && m_axis.tready;

  // A sof beat is pixel 0 of line 0; a full line always leaves with eol set.
  always_comb begin
    cur_px   = px;
    cur_ln   = ln;
    if (s_pix.sof) begin
      cur_px = '0;
      cur_ln = '0;
    end
    wr_en     = accept && ((state == IN_FRAME) || s_pix.sof);
    eol_fix   = s_pix.eol || (cur_px == PX_LAST);
    line_end  = wr_en && eol_fix;
    frame_end = line_end && (cur_ln == LN_LAST);
    err_set                  = '0;
    err_set[ERR_EARLY_EOL]   = wr_en && s_pix.eol && (cur_px != PX_LAST);
    err_set[ERR_MISSING_EOL] = wr_en && !s_pix.eol && (cur_px == PX_LAST);
    err_set[ERR_UNEXP_SOF]   = wr_en && s_pix.sof && (state == IN_FRAME);
    wr_entry = {s_pix.sof, eol_fix, s_pix.data};
  end

  // Framing state, counters, frame-done pulse and sticky errors (set wins over clear).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= WAIT_SOF;
      px           <= '0;
      ln           <= '0;
      o_frame_done <= 1'b0;
      o_err        <= '0;
    end else begin
      o_frame_done <= frame_end;
      o_err        <= (i_clear_err ? ERR_W'(0) : o_err) | err_set;
      if (wr_en) begin
        if (frame_end) begin
          state <= WAIT_SOF;
          px    <= '0;
          ln    <= '0;
        end else if (line_end) begin
          state <= IN_FRAME;
          px    <= '0;
          ln    <= cur_ln + LN_W'(1);
        end else begin
          state <= IN_FRAME;
          px    <= cur_px + PX_W'(1);
          ln    <= cur_ln;
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (wr_en),
    .i_wr_data (wr_entry),
    .i_rd_en   (rd_en),
    .o_rd_data (rd_entry),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_count   (o_fifo_count)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = rd_entry[PIXEL_W-1:0];
  assign m_axis.tlast  = rd_entry[PIXEL_W];
  assign m_axis.tuser  = rd_entry[PIXEL_W+1];

endmodule
